// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader
//
// Feeds a logic tile's configuration chain from a byte-wide host stream.
// Bytes arrive over a valid/ready handshake. Exactly CHAIN_LEN bits are
// shifted MSB-first into ccff_head, one bit per prog_clk. A one-byte holding
// buffer lets the next byte wait while the current one shifts, so the stream
// has no gap at byte boundaries.
//
// Optional feature: define CCFF_TAIL_CRC_EN to build a CRC-16 (0x1021,
// MSB-first, init 0) over the ccff_tail samples. Without it, tail_crc is 0.
//
// Ports:
//   prog_clk       programming clock (only clock)
//   pReset         asynchronous active-high reset
//   start          one-cycle pulse that begins a load (ignored while busy)
//   in_data        configuration byte, bit 7 shifted first
//   in_valid       in_data is valid
//   in_ready       loader accepts a byte this cycle (combinational)
//   ccff_head      serial bit to the chain head
//   ccff_shift_en  chain clock-enable
//   ccff_tail      serial bit returning from the chain tail
//   busy           load in progress
//   done           one-cycle pulse after the last bit has been shifted
//   bit_count      bits shifted so far in the current load
//   tail_crc       CRC of the sampled ccff_tail bits
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 20,
  parameter int CW        = $clog2(CHAIN_LEN + 1)
) (
  input  logic          prog_clk,
  input  logic          pReset,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          ccff_head,
  output logic          ccff_shift_en,
  input  logic          ccff_tail,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] bit_count,
  output logic [15:0]   tail_crc
);

  localparam int            NBYTES   = (CHAIN_LEN + 7) / 8;
  localparam int            BW       = $clog2(NBYTES + 1);
  localparam logic [BW-1:0] NBYTES_W = BW'(NBYTES);
  localparam logic [CW-1:0] LAST_IDX = CW'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [6:0]    sreg_q, sreg_d;      // bits of the current byte still to follow head
  logic [2:0]    rem_q, rem_d;        // how many of those remain
  logic [7:0]    buf_q, buf_d;
  logic          buf_full_q, buf_full_d;
  logic [BW-1:0] bytes_q, bytes_d;
  logic [CW-1:0] bit_count_q, bit_count_d;
  logic          head_q, head_d;
  logic          shift_en_q, shift_en_d;
  logic          done_q, done_d;
  logic          xfer;

  assign in_ready = ((state_q == S_WAIT) || (state_q == S_SHIFT && !buf_full_q))
                    && (bytes_q < NBYTES_W);
  assign xfer     = in_valid && in_ready;

  // head_q/shift_en_q hold the bit presented to the chain during the current
  // cycle; the chain consumes it at the next edge, which is when bit_count
  // advances.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    rem_d       = rem_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    bytes_d     = bytes_q;
    bit_count_d = bit_count_q;
    head_d      = head_q;
    shift_en_d  = shift_en_q;
    done_d      = 1'b0;

    if (xfer) bytes_d = bytes_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_WAIT;
          bit_count_d = '0;
          bytes_d     = '0;
          buf_full_d  = 1'b0;
          head_d      = 1'b0;
          shift_en_d  = 1'b0;
        end
      end
      S_WAIT: begin
        if (xfer) begin
          head_d     = in_data[7];
          sreg_d     = in_data[6:0];
          rem_d      = 3'd7;
          shift_en_d = 1'b1;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bit_count_d = bit_count_q + 1'b1;
        if (xfer) begin
          buf_d      = in_data;
          buf_full_d = 1'b1;
        end
        if (bit_count_q == LAST_IDX) begin
          // Whatever is left of the final byte is dropped.
          state_d    = S_DONE;
          done_d     = 1'b1;
          shift_en_d = 1'b0;
          head_d     = 1'b0;
        end else if (rem_q != 3'd0) begin
          head_d = sreg_q[6];
          sreg_d = {sreg_q[5:0], 1'b0};
          rem_d  = rem_q - 1'b1;
        end else if (buf_full_q) begin
          head_d     = buf_q[7];
          sreg_d     = buf_q[6:0];
          rem_d      = 3'd7;
          buf_full_d = 1'b0;
        end else if (xfer) begin
          // A byte arriving exactly on the boundary goes straight into the
          // shifter instead of bouncing through the buffer and WAIT.
          head_d     = in_data[7];
          sreg_d     = in_data[6:0];
          rem_d      = 3'd7;
          buf_full_d = 1'b0;
        end else begin
          state_d    = S_WAIT;
          shift_en_d = 1'b0;
          head_d     = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q     <= S_IDLE;
      sreg_q      <= '0;
      rem_q       <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      bytes_q     <= '0;
      bit_count_q <= '0;
      head_q      <= 1'b0;
      shift_en_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      rem_q       <= rem_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      bytes_q     <= bytes_d;
      bit_count_q <= bit_count_d;
      head_q      <= head_d;
      shift_en_q  <= shift_en_d;
      done_q      <= done_d;
    end
  end

  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign bit_count     = bit_count_q;

`ifdef CCFF_TAIL_CRC_EN
  logic [15:0] crc_q, crc_d;

  // One update per edge on which the chain shifts, i.e. one per tail sample.
  always_comb begin
    crc_d = crc_q;
    if (state_q == S_IDLE && start) begin
      crc_d = 16'h0000;
    end else if (shift_en_q) begin
      crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ ccff_tail) ? 16'h1021 : 16'h0000);
    end
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) crc_q <= 16'h0000;
    else        crc_q <= crc_d;
  end

  assign tail_crc = crc_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign tail_crc    = 16'h0000;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
module tb_ccff_bitstream_loader;

  localparam int CHAIN_LEN = 20;
  localparam int CW        = $clog2(CHAIN_LEN + 1);
  // 1010 0101 0011 1100 1111
  localparam logic [31:0] EXP_HEAD = 32'h000A53CF;

  logic          prog_clk = 1'b0;
  logic          pReset;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          ccff_head;
  logic          ccff_shift_en;
  logic          ccff_tail;
  logic          busy;
  logic          done;
  logic [CW-1:0] bit_count;
  logic [15:0]   tail_crc;

  ccff_bitstream_loader #(.CHAIN_LEN(CHAIN_LEN)) dut (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .start         (start),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .bit_count     (bit_count),
    .tail_crc      (tail_crc)
  );

  always #5 prog_clk = ~prog_clk;

  logic [7:0]  byte_mem [0:3] = '{8'hA5, 8'h3C, 8'hF0, 8'h99};
  int          errors = 0;
  int          checks = 0;
  int          acc, shift_cnt, gap_cnt, done_cnt, ready_after_limit;
  logic [31:0] head_cap;
  bit          tail_last_one;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One clock: note the handshake mid-cycle, then sample #1 after the edge
  // and prepare the next inputs.
  task automatic step();
    bit xfer;
    #4;
    xfer = in_valid && in_ready;
    @(posedge prog_clk);
    #1;
    if (xfer) acc++;
    if (acc >= 3 && in_ready) ready_after_limit++;
    if (ccff_shift_en) begin
      head_cap = {head_cap[30:0], ccff_head};
      shift_cnt++;
    end else if (busy && shift_cnt > 0 && !done) begin
      gap_cnt++;
    end
    if (done) done_cnt++;
    ccff_tail = tail_last_one && ccff_shift_en && (shift_cnt == CHAIN_LEN);
    in_data   = byte_mem[(acc > 3) ? 3 : acc];
  endtask

  task automatic clear_monitor(input bit tail_one);
    acc = 0; shift_cnt = 0; gap_cnt = 0; done_cnt = 0;
    ready_after_limit = 0; head_cap = '0; tail_last_one = tail_one;
    ccff_tail = 1'b0;
  endtask

  task automatic run_load(input string name, input int stall_wait, input int start_at,
                          input bit tail_one);
    bit          pulsed = 1'b0;
    logic [15:0] exp_crc;
    clear_monitor(tail_one);
    in_data  = byte_mem[0];
    in_valid = 1'b1;
    start    = 1'b1;
    step();
    start    = 1'b0;
    check({name, "_busy_after_start"}, busy, 1);
    for (int c = 0; c < 300 && done_cnt == 0; c++) begin
      // Hold the second byte back until WAIT has been seen for stall_wait cycles.
      in_valid = !(stall_wait > 0 && acc == 1 && gap_cnt < stall_wait);
      if (start_at > 0 && shift_cnt == start_at && !pulsed) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      step();
      start = 1'b0;
      if (stall_wait > 0 && acc == 1 && shift_cnt == 8 && !done)
        check({name, "_wait_ready"}, in_ready, 1);
    end
    check({name, "_done_seen"}, done_cnt, 1);
    check({name, "_bit_count_at_done"}, bit_count, CHAIN_LEN);
    step();
    step();
    in_valid = 1'b0;
    check({name, "_head_seq"}, head_cap & 32'h000FFFFF, EXP_HEAD);
    check({name, "_shift_cycles"}, shift_cnt, CHAIN_LEN);
    check({name, "_gap_cycles"}, gap_cnt, stall_wait);
    check({name, "_done_pulses"}, done_cnt, 1);
    check({name, "_bytes_accepted"}, acc, 3);
    check({name, "_ready_after_limit"}, ready_after_limit, 0);
    check({name, "_idle_busy"}, busy, 0);
    check({name, "_bit_count_hold"}, bit_count, CHAIN_LEN);
`ifdef CCFF_TAIL_CRC_EN
    exp_crc = tail_one ? 16'h1021 : 16'h0000;
`else
    exp_crc = 16'h0000;
`endif
    check({name, "_tail_crc"}, tail_crc, exp_crc);
    $display("load %s: head=0x%05h shifts=%0d gaps=%0d bytes=%0d crc=0x%04h",
             name, head_cap[19:0], shift_cnt, gap_cnt, acc, tail_crc);
  endtask

  task automatic reset_mid_load();
    clear_monitor(1'b0);
    in_data  = byte_mem[0];
    in_valid = 1'b1;
    start    = 1'b1;
    step();
    start    = 1'b0;
    for (int c = 0; c < 100 && shift_cnt < 11; c++) step();
    check("rst_pre_shifts", shift_cnt, 11);
    check("rst_pre_bit_count", bit_count, 10);
    check("rst_pre_head", ccff_head, 1);
    #2;
    pReset = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_head", ccff_head, 0);
    check("rst_shift_en", ccff_shift_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bit_count", bit_count, 0);
    check("rst_tail_crc", tail_crc, 0);
    in_valid = 1'b0;
    step();
    step();
    check("rst_held_busy", busy, 0);
    pReset = 1'b0;
    $display("load reset_mid: aborted after %0d bits", 10);
  endtask

  initial begin
    pReset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    ccff_tail = 1'b0; tail_last_one = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 0);
    check("reset_head", ccff_head, 0);
    check("reset_shift_en", ccff_shift_en, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_bit_count", bit_count, 0);
    check("reset_tail_crc", tail_crc, 0);
    @(posedge prog_clk); #1;
    @(posedge prog_clk); #1;
    pReset = 1'b0;

    run_load("basic", 0, 0, 1'b0);
    run_load("stall", 5, 0, 1'b0);
    run_load("start_busy", 0, 7, 1'b0);
    reset_mid_load();
    run_load("after_reset", 0, 0, 1'b0);
    run_load("crc_last_one", 0, 0, 1'b1);
    run_load("crc_zero", 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ccff_bitstream_loader.md
# ccff_bitstream_loader

Programming-side loader that sits directly upstream of a logic tile's configuration chain and drives its `ccff_head`. It accepts configuration bytes from the host interface over a valid/ready handshake and serializes exactly `CHAIN_LEN` bits MSB-first into the chain, one bit per `prog_clk`. A one-byte holding buffer keeps the stream gap-free, so a full byte is shifted every 8 cycles. It also samples the returning `ccff_tail`.

## Interface
- `CHAIN_LEN`, default 20: number of configuration bits in the downstream chain; must be ≥1.
- `CW`, default `$clog2(CHAIN_LEN+1)`: width of the bit counter.
- `prog_clk`  in  1  programming clock; the only clock.
- `pReset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a load; ignored while `busy`.
- `in_data`  in  8  configuration byte; bit 7 is shifted first.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `ccff_head`  out  1  serial bit to the chain head.
- `ccff_shift_en`  out  1  chain clock-enable. The chain shifts on every `prog_clk` edge where this is high.
- `ccff_tail`  in  1  serial bit returning from the chain tail.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse when the last bit has been shifted.
- `bit_count`  out  CW  bits shifted so far in the current load.
- `tail_crc`  out  16  CRC of the bits observed on `ccff_tail` (see Configuration).

## Operation
- States: IDLE, WAIT, SHIFT, DONE.
- IDLE → WAIT on `start`. The transition clears `bit_count`, the bytes-requested counter, and the CRC.
- WAIT: shifter is empty and `ccff_shift_en`=0. When a byte is accepted, it loads directly into the shifter → SHIFT.
- SHIFT: every cycle drives `ccff_head` = shifter MSB and `ccff_shift_en`=1, left-shifts, and increments `bit_count`.
  - After 8 bits, if the holding buffer is full, it reloads from the buffer with no gap. Otherwise it goes → WAIT.
- When `bit_count` reaches `CHAIN_LEN` → DONE. Remaining bits of the final byte are discarded.
- DONE: `done`=1 for one cycle, then → IDLE.
- `in_ready` = (WAIT, or SHIFT with buffer empty) and bytes accepted < ceil(`CHAIN_LEN`/8). No byte is ever accepted beyond that count.
- A transfer occurs only when `in_valid` and `in_ready` are both high in the same cycle. Data is captured at that edge.
- `busy` = state ≠ IDLE.
- `start` while busy: ignored, with no effect on state or counters.
- `pReset` mid-load: immediate return to IDLE. The chain is left partially written, and the host must restart the load.

## Timing
- Reset values: `in_ready`=0, `ccff_head`=0, `ccff_shift_en`=0, `busy`=0, `done`=0, `bit_count`=0, `tail_crc`=0.
- All outputs are registered except `in_ready`, which is combinational from state, buffer-full and byte count.
- `ccff_head` and `ccff_shift_en` change together. The chain captures `ccff_head` at the first edge where both are visible.
- The first `ccff_shift_en` cycle is one cycle after the first accepted byte.
- Sustained rate: 1 bit/cycle while the host keeps `in_valid` high.
- `done` asserts on the cycle after the `CHAIN_LEN`-th `ccff_shift_en` cycle.
- `ccff_tail` is sampled on each edge where `ccff_shift_en`=1, giving exactly `CHAIN_LEN` samples per load.

## Configuration
- `CCFF_TAIL_CRC_EN` defined:
  - CRC-16 over the sampled `ccff_tail` bits, polynomial x^16+x^12+x^5+1 (0x1021), bit-serial, MSB-first, init 0x0000.
  - The register is cleared on `start` and updated once per sample.
  - `tail_crc` is stable from `done` until the next `start`.
- Not defined: no CRC logic is built, `ccff_tail` is unused, and `tail_crc` is tied to 0.

## Test plan
- Basic load: `CHAIN_LEN`=20, `in_valid` held, bytes 0xA5, 0x3C, 0xF0.
  - `ccff_head` over the 20 shift cycles = 1010 0101 0011 1100 1111.
  - `ccff_shift_en` is high for exactly 20 contiguous cycles, with no gap at the byte boundaries.
  - `done` pulses once; `bit_count`=20.
- Host stall: withhold `in_valid` for 5 cycles after the first byte.
  - State enters WAIT and `ccff_shift_en`=0 for those cycles.
  - The final head sequence is unchanged, still 20 bits.
- Byte limit: offer a 4th byte after 3 have been accepted.
  - `in_ready` stays 0, and the 4th byte is never consumed.
- `start` during busy: pulse `start` at bit 7 → no restart, and `bit_count` continues to 20.
- Async reset: assert `pReset` at bit 10 (mid-cycle).
  - Outputs go to reset values immediately.
  - A new `start` produces a full 20-bit load.
- CRC (`CCFF_TAIL_CRC_EN`):
  - `ccff_tail`=0 for all 20 samples → `tail_crc`=0x0000.
  - 19 zeros then a final 1 → `tail_crc`=0x1021.
  - Without the macro, `tail_crc`=0x0000 in both cases.
